operand_hazard_ctrl: RTL
========================

Name: operand_hazard_ctrl

Overview:
- Pipeline control block for the EX-stage ALU operand path of the 5-stage RV32I core.
- Decodes the ID-stage instruction and tracks destination registers through EX/MEM/WB in its own shadow pipeline.
- Outputs: the registered operand-A source select (PC vs rs1), forwarding selects for operands A/B, load-use stall and branch flush control.
- Sits beside the IF/ID and ID/EX pipeline registers; drives the operand-A mux select and the forwarding muxes.

Parameters:
- LOAD_USE_STALLS, 1, bubble cycles inserted on a load-use hazard (1..7; data memory latency).
- XLEN_REGS, 32, number of architectural registers; register index width fixed at 5.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID-stage holds a real instruction
- id_opcode  in  7  ID-stage opcode field
- id_rs1  in  5  ID-stage rs1 index
- id_rs2  in  5  ID-stage rs2 index
- id_rd  in  5  ID-stage rd index
- branch_taken  in  1  EX-stage resolved redirect (branch taken, JAL, JALR)
- A_sel  out  1  EX-stage operand A select: 1 = PC, 0 = rs1
- fwdA  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwdB  out  2  same encoding for operand B
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  turn IF/ID into a bubble
- flush_idex  out  1  turn ID/EX into a bubble

Behaviour:
- ID decode (combinational):
  - uses_rs1 = not (LUI 0110111, AUIPC 0010111, JAL 1101111).
  - uses_rs2 = R 0110011, S 0100011, B 1100011.
  - writes_rd = not (S, B) and id_rd != 0.
  - is_load = 0000011.
  - asel_d = 1 for AUIPC, JAL, B; else 0.
- Shadow pipeline registers, each holding valid, rd, regwrite, memread, rs1, rs2, asel:
  - EX register loads from ID each cycle.
  - MEM and WB registers shift every cycle.
- A_sel = asel of the EX register; it is registered, so it is valid in the same cycle the instruction is in EX.
- fwdA:
  - 01 when MEM valid, MEM regwrite, MEM rd == EX rs1, rd != 0.
  - Otherwise 10 when the same conditions hold for WB.
  - Otherwise 00.
  - MEM wins over WB.
  - Forced to 00 when EX asel = 1 or EX does not use rs1.
- fwdB: same rules on rs2; forced to 00 when EX does not use rs2.
- x0 is never forwarded.
- Load-use hazard, when all hold:
  - id_valid = 1;
  - EX valid and EX memread;
  - EX rd != 0;
  - (uses_rs1 and id_rs1 == EX rd) or (uses_rs2 and id_rs2 == EX rd).
- Stall FSM states:
  - RUN: load-use hazard -> assert stall and flush_idex in the same cycle; go to STALL with cnt = LOAD_USE_STALLS-1 if LOAD_USE_STALLS > 1, else stay in RUN.
  - STALL: stall = 1, flush_idex = 1; cnt decrements each cycle; at cnt == 0, return to RUN on the next edge.
- A bubble enters EX with valid = 0, regwrite = 0, memread = 0, asel = 0.
- branch_taken:
  - flush_ifid = 1 and flush_idex = 1 in the same cycle; stall = 0.
  - FSM forced to RUN and cnt cleared.
  - Overrides any load-use hazard in the same cycle.
- id_valid = 0: no hazard; a bubble propagates.
- Reset (async, immediate):
  - all shadow valid/regwrite/memread = 0, FSM = RUN, cnt = 0;
  - outputs A_sel = 0, fwdA = fwdB = 00, stall = 0, flush_ifid = flush_idex = 0.
- Reset mid-stall abandons the stall with no residual bubbles.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- With the macro defined:
  - adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0;
  - stall_cycles increments every cycle stall = 1;
  - flush_events increments once per cycle with branch_taken = 1;
  - both wrap at 2^32.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- addi x5,x0,1 then add x6,x5,x5 back-to-back -> add in EX sees fwdA=01, fwdB=01, stall=0.
- addi x5, nop, add x6,x5,x0 -> fwdA=10; with x5 written in both MEM and WB, fwdA=01 (MEM priority).
- lw x7,0(x1) then add x8,x7,x2 with LOAD_USE_STALLS=1 -> exactly 1 cycle stall=1/flush_idex=1; add then sees fwdA=10. With LOAD_USE_STALLS=3 -> 3 stall cycles.
- auipc x3,0x1 in EX -> A_sel=1, fwdA=00 even when MEM rd==x0/any; jal -> A_sel=1; add -> A_sel=0.
- lw x7 then add x8,x7 with branch_taken=1 in the hazard cycle -> stall=0, flush_ifid=1, flush_idex=1, FSM in RUN next cycle.
- Write to x0 (addi x0,x0,5) followed by add x1,x0,x0 -> fwdA=fwdB=00, no stall. Assert rst mid-STALL -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// operand_hazard_ctrl
//
// Hazard and operand-path control for the EX-stage ALU of a 5-stage RV32I
// core. The block decodes the ID-stage instruction and copies what it needs
// into a shadow pipeline (EX -> MEM -> WB) that runs alongside the real
// pipeline registers. From that shadow state it produces:
//   - the registered operand-A source select (PC or rs1),
//   - the forwarding selects for ALU operands A and B,
//   - load-use stall control (hold PC and IF/ID, bubble ID/EX),
//   - branch/jump redirect flush control.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous, active-high reset
//   id_valid       ID stage holds a real instruction
//   id_opcode      ID-stage opcode field [6:0]
//   id_rs1/rs2/rd  ID-stage register indices [4:0]
//   branch_taken   EX-stage resolved redirect (taken branch, JAL, JALR)
//   A_sel          EX operand A select: 1 = PC, 0 = rs1
//   fwdA, fwdB     EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall          hold PC and IF/ID this cycle
//   flush_ifid     turn IF/ID into a bubble
//   flush_idex     turn ID/EX into a bubble
//
// Optional feature (macro HAZ_PERF_CNT_EN)
//   Adds stall_cycles[31:0] (cycles with stall = 1) and flush_events[31:0]
//   (cycles with branch_taken = 1). Both reset to 0 and wrap at 2^32.
//
// Parameters
//   LOAD_USE_STALLS  bubble cycles per load-use hazard (1..7)
//   XLEN_REGS        number of architectural registers (index width is 5)
// ----------------------------------------------------------------------------
module operand_hazard_ctrl #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int XLEN_REGS       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        branch_taken,
    output logic        A_sel,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        stall,
    output logic        flush_ifid,
`ifdef HAZ_PERF_CNT_EN
    output logic        flush_idex,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`else
    output logic        flush_idex
`endif
);

    // RV32I major opcodes that matter for operand usage
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Counter reload when entering STALL; the hazard cycle itself is the
    // first bubble, so STALL covers the remaining LOAD_USE_STALLS-1 cycles.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALLS - 1);

    // Full record for the instruction in EX: everything forwarding and
    // load-use detection need to look at.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       asel;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_stage_t;

    // MEM and WB only act as forwarding sources, so they carry the writer
    // identity alone.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [4:0] rd;
    } wr_stage_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    ex_stage_t id_dec;
    ex_stage_t ex_d;
    ex_stage_t ex_q;
    wr_stage_t mem_q;
    wr_stage_t wb_q;
    state_t    state_q;
    state_t    state_n;
    logic [2:0] cnt_q;
    logic [2:0] cnt_n;

    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic load_use;
    logic stall_c;
    logic flush_ifid_c;
    logic flush_idex_c;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        uses_rs1  = !((id_opcode == OPC_LUI) || (id_opcode == OPC_AUIPC) ||
                      (id_opcode == OPC_JAL));
        uses_rs2  = (id_opcode == OPC_RTYPE) || (id_opcode == OPC_STORE) ||
                    (id_opcode == OPC_BRANCH);
        // Indices at or beyond XLEN_REGS name no real register (RV32E-style
        // builds), so they never count as a write.
        writes_rd = !((id_opcode == OPC_STORE) || (id_opcode == OPC_BRANCH)) &&
                    (id_rd != 5'd0) && ({27'd0, id_rd} < 32'(XLEN_REGS));

        id_dec          = '0;
        id_dec.valid    = 1'b1;
        id_dec.regwrite = writes_rd;
        id_dec.memread  = (id_opcode == OPC_LOAD);
        id_dec.asel     = (id_opcode == OPC_AUIPC) || (id_opcode == OPC_JAL) ||
                          (id_opcode == OPC_BRANCH);
        id_dec.use_rs1  = uses_rs1;
        id_dec.use_rs2  = uses_rs2;
        id_dec.rd       = id_rd;
        id_dec.rs1      = id_rs1;
        id_dec.rs2      = id_rs2;
    end

    // Load-use: the instruction in ID reads a register the load in EX has
    // not produced yet.
    assign load_use = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                      ((uses_rs1 && (id_rs1 == ex_q.rd)) ||
                       (uses_rs2 && (id_rs2 == ex_q.rd)));

    // ------------------------------------------------------------------
    // Stall / flush FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        stall_c      = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;

        if (branch_taken) begin
            // A redirect squashes both younger instructions, so any pending
            // load-use stall is moot.
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
            state_n      = ST_RUN;
            cnt_n        = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        stall_c      = 1'b1;
                        flush_idex_c = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_n = ST_STALL;
                            cnt_n   = STALL_RELOAD;
                        end
                    end
                end
                ST_STALL: begin
                    stall_c      = 1'b1;
                    flush_idex_c = 1'b1;
                    // Leave on the edge where the count reaches zero, giving
                    // STALL_RELOAD cycles in this state.
                    if (cnt_q <= 3'd1) begin
                        state_n = ST_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end
            endcase
        end

        // Bubble into EX on flush or when ID is empty.
        ex_d = (id_valid && !flush_idex_c) ? id_dec : '0;
    end

    // ------------------------------------------------------------------
    // Shadow pipeline and FSM state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, exactly like real flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= '{valid: ex_q.valid, regwrite: ex_q.regwrite, rd: ex_q.rd};
            wb_q    <= mem_q;
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                           input wr_stage_t mem, input wr_stage_t wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used) begin
            // MEM holds the younger write, so it takes priority over WB.
            if (mem.valid && mem.regwrite && (mem.rd == rs) && (mem.rd != 5'd0))
                sel = FWD_MEM;
            else if (wb.valid && wb.regwrite && (wb.rd == rs) && (wb.rd != 5'd0))
                sel = FWD_WB;
        end
        return sel;
    endfunction

    // Operand A is not rs1 when the ALU takes the PC.
    assign fwdA  = fwd_sel(ex_q.rs1, ex_q.use_rs1 && !ex_q.asel, mem_q, wb_q);
    assign fwdB  = fwd_sel(ex_q.rs2, ex_q.use_rs2, mem_q, wb_q);
    assign A_sel = ex_q.asel;

    // Control outputs are held quiet while reset is asserted, even if a
    // redirect is presented.
    assign stall      = stall_c      && !rst;
    assign flush_ifid = flush_ifid_c && !rst;
    assign flush_idex = flush_idex_c && !rst;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule
